// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: serialises LSB loads/stores and instruction fetches onto the byte-wide RAM/IO port
module mem_ctrl_arbiter #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = 'h30000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              Mem_S,
    input  logic              Mem_op,
    input  logic [ADDR_W-1:0] Mem_pc,
    input  logic [2:0]        Mem_len,
    input  logic [31:0]       Mem_result,
    output logic              Mem_success,
    output logic [31:0]       Mem_value,
    input  logic              IF_S,
    input  logic [ADDR_W-1:0] IF_pc,
    output logic              IF_success,
    output logic [31:0]       IF_inst,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, GAP} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_a;
    logic [2:0]        r_len;
    logic [2:0]        r_cnt;
    logic              r_op;
    logic              r_own;
    logic [31:0]       r_wdat;
    logic [31:0]       r_data;
    logic [31:0]       r_mval;
    logic [31:0]       r_inst;
    logic [7:0]        r_dout;
    logic              r_wr;
    logic              r_msucc;
    logic              r_isucc;
    logic [ADDR_W-1:0] w_addr_k;
    logic [1:0]        w_lane;
    logic [31:0]       w_cap;
    logic              w_stall;
    assign w_addr_k    = r_addr + {{(ADDR_W-3){1'b0}}, r_cnt};
    assign w_lane      = 2'(r_cnt - 3'd2);
    assign w_stall     = (w_addr_k >= IO_BASE) && io_buffer_full;
    assign Mem_success = r_msucc & rdy & ~(clr & ~r_op);
    assign IF_success  = r_isucc & rdy & ~clr;
    assign Mem_value   = r_mval;
    assign IF_inst     = r_inst;
    assign mem_a       = r_a;
    assign mem_dout    = r_dout;
    assign mem_wr      = r_wr & rdy;
    // read data with the byte arriving this cycle merged into its lane
    always_comb begin
        w_cap = r_data;
        w_cap[{w_lane, 3'b000} +: 8] = mem_din;
    end
    // request acceptance, byte sequencing and completion handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_a     <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_own   <= 1'b0;
            r_wdat  <= '0;
            r_data  <= '0;
            r_mval  <= '0;
            r_inst  <= '0;
            r_dout  <= '0;
            r_wr    <= 1'b0;
            r_msucc <= 1'b0;
            r_isucc <= 1'b0;
        end else if (rdy) begin
            case (r_state)
                IDLE: if (Mem_S || IF_S) begin
                    r_addr  <= Mem_S ? Mem_pc : IF_pc;
                    r_len   <= Mem_S ? Mem_len : 3'd4;
                    r_op    <= Mem_S & Mem_op;
                    r_own   <= ~Mem_S;
                    r_wdat  <= Mem_result;
                    r_data  <= '0;
                    r_cnt   <= '0;
                    r_state <= (Mem_S && Mem_op) ? WRITE : READ;
                end
                READ: if (clr) begin
                    r_state <= GAP;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt < r_len) r_a <= w_addr_k;
                    if (r_cnt >= 3'd2) r_data <= w_cap;
                    if (r_cnt == r_len + 3'd1) begin
                        r_state <= DONE;
                        r_msucc <= ~r_own;
                        r_isucc <= r_own;
                        if (r_own) r_inst <= w_cap;
                        else r_mval <= w_cap;
                    end
                end
                // stores ignore clr: a committed store must retire
                WRITE: if (r_cnt == r_len) begin
                    r_wr    <= 1'b0;
                    r_msucc <= 1'b1;
                    r_state <= DONE;
                end else if (w_stall) begin
                    r_wr <= 1'b0;
                end else begin
                    r_a    <= w_addr_k;
                    r_dout <= r_wdat[{r_cnt[1:0], 3'b000} +: 8];
                    r_wr   <= 1'b1;
                    r_cnt  <= r_cnt + 3'd1;
                end
                DONE: begin
                    r_msucc <= 1'b0;
                    r_isucc <= 1'b0;
                    r_state <= GAP;
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb_mem_ctrl_arbiter: directed scoreboard bench with a byte RAM model behind the port
module tb_mem_ctrl_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic        Mem_S = 1'b0;
    logic        Mem_op = 1'b0;
    logic [31:0] Mem_pc = '0;
    logic [2:0]  Mem_len = '0;
    logic [31:0] Mem_result = '0;
    logic        Mem_success;
    logic [31:0] Mem_value;
    logic        IF_S = 1'b0;
    logic [31:0] IF_pc = '0;
    logic        IF_success;
    logic [31:0] IF_inst;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    typedef struct { logic [31:0] v; int c; bit chkv; } exp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
    exp_t exp_m[$];
    exp_t exp_i[$];
    wr_t  exp_w[$];
    exp_t em, ei;
    wr_t  ew;
    logic [7:0] ram [logic [31:0]];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    mem_ctrl_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .Mem_S(Mem_S), .Mem_op(Mem_op), .Mem_pc(Mem_pc), .Mem_len(Mem_len),
        .Mem_result(Mem_result), .Mem_success(Mem_success), .Mem_value(Mem_value),
        .IF_S(IF_S), .IF_pc(IF_pc), .IF_success(IF_success), .IF_inst(IF_inst),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] rb(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [31:0] rd_val(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rb(a + 32'(k));
        return v;
    endfunction

    // RAM/IO model: one-cycle read latency, writes land on the edge
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a] = mem_dout;
        mem_din <= rb(mem_a);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // scoreboard: every pulse and write byte must match the next queued expectation
    always @(negedge clk) begin
        if (Mem_success) begin
            chk("mem_pulse_expected", 32'(exp_m.size() != 0), 32'd1);
            if (exp_m.size() != 0) begin
                em = exp_m.pop_front();
                chk("mem_cycle", 32'(cyc), 32'(em.c));
                if (em.chkv) chk("mem_value", Mem_value, em.v);
            end
        end
        if (IF_success) begin
            chk("if_pulse_expected", 32'(exp_i.size() != 0), 32'd1);
            if (exp_i.size() != 0) begin
                ei = exp_i.pop_front();
                chk("if_cycle", 32'(cyc), 32'(ei.c));
                chk("if_inst", IF_inst, ei.v);
            end
        end
        if (mem_wr) begin
            chk("wr_expected", 32'(exp_w.size() != 0), 32'd1);
            if (exp_w.size() != 0) begin
                ew = exp_w.pop_front();
                chk("wr_addr", mem_a, ew.a);
                chk("wr_data", 32'(mem_dout), 32'(ew.d));
            end
        end
    end

    task automatic lsb(input logic op, input logic [31:0] a, input int n, input logic [31:0] d, input int extra);
        exp_t e;
        wr_t  w;
        e.v = op ? 32'h0 : rd_val(a, n);
        e.c = cyc + 1 + (op ? n + 1 : n + 2) + extra;
        e.chkv = !op;
        exp_m.push_back(e);
        if (op) for (int k = 0; k < n; k++) begin
            w.a = a + 32'(k);
            w.d = d[8*k +: 8];
            exp_w.push_back(w);
        end
        Mem_op = op; Mem_pc = a; Mem_len = 3'(n); Mem_result = d; Mem_S = 1'b1;
    endtask

    task automatic wait_succ(input bit is_if);
        int t = 0;
        while (!(is_if ? IF_success : Mem_success) && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (is_if) chk("if_timeout", 32'(t < 80), 32'd1);
        else chk("mem_timeout", 32'(t < 80), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_mem_success", 32'(Mem_success), 32'd0);
        chk("rst_if_success", 32'(IF_success), 32'd0);
        chk("rst_mem_value", Mem_value, 32'd0);
        chk("rst_if_inst", IF_inst, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        // LSB read, 4 bytes, address sequence checked byte by byte
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        lsb(1'b0, 32'h100, 4, 32'h0, 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rd_addr_seq", mem_a, 32'h100 + 32'(k));
            chk("rd_no_wr", 32'(mem_wr), 32'd0);
        end
        wait_succ(1'b0);
        Mem_S = 1'b0;
        // LSB write, 2 bytes, request held through the gap
        lsb(1'b1, 32'h200, 2, 32'hAABBCCDD, 0);
        wait_succ(1'b0);
        Mem_S = 1'b0;
        // simultaneous requests: LSB first, fetch right after the gap
        ram[32'h300] = 8'h80;
        ram[32'h400] = 8'h01; ram[32'h401] = 8'h02; ram[32'h402] = 8'h03; ram[32'h403] = 8'h04;
        c0 = cyc;
        e.v = 32'h04030201; e.c = c0 + 13; e.chkv = 1'b1;
        exp_i.push_back(e);
        lsb(1'b0, 32'h300, 1, 32'h0, 0);
        IF_pc = 32'h400; IF_S = 1'b1;
        wait_succ(1'b0);
        Mem_S = 1'b0;
        wait_succ(1'b1);
        IF_S = 1'b0;
        // IO write stalled by a full buffer for three edges
        io_buffer_full = 1'b1;
        lsb(1'b1, 32'h30000, 1, 32'h0000005A, 3);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("io_stall_no_wr", 32'(mem_wr), 32'd0);
        end
        io_buffer_full = 1'b0;
        wait_succ(1'b0);
        Mem_S = 1'b0;
        // flush during a fetch aborts it with no pulse
        IF_pc = 32'h500; IF_S = 1'b1;
        repeat (3) @(negedge clk);
        chk("if_mid_addr", mem_a, 32'h501);
        clr = 1'b1; IF_S = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        repeat (8) @(negedge clk);
        // flush during a store does not abort it
        lsb(1'b1, 32'h600, 4, 32'h0D0C0B0A, 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        wait_succ(1'b0);
        Mem_S = 1'b0;
        // flush in the completion cycle of a read suppresses the pulse
        ram[32'h700] = 8'h77;
        Mem_op = 1'b0; Mem_pc = 32'h700; Mem_len = 3'd1; Mem_S = 1'b1;
        repeat (4) @(posedge clk);
        #1 clr = 1'b1;
        #1 chk("clr_done_suppress", 32'(Mem_success), 32'd0);
        @(posedge clk);
        #1 clr = 1'b0; Mem_S = 1'b0;
        repeat (3) @(negedge clk);
        // asynchronous reset between edges mid-read
        Mem_op = 1'b0; Mem_pc = 32'h100; Mem_len = 3'd4; Mem_S = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_mem_a", mem_a, 32'd0);
        chk("arst_mem_value", Mem_value, 32'd0);
        chk("arst_if_inst", IF_inst, 32'd0);
        chk("arst_mem_success", 32'(Mem_success), 32'd0);
        @(negedge clk);
        rst = 1'b1; Mem_S = 1'b0;
        repeat (2) @(negedge clk);
        // rdy low for two edges mid-read freezes everything
        lsb(1'b0, 32'h100, 4, 32'h0, 2);
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        @(negedge clk);
        chk("rdy_freeze_a0", mem_a, 32'h100);
        @(negedge clk);
        chk("rdy_freeze_a1", mem_a, 32'h100);
        rdy = 1'b1;
        wait_succ(1'b0);
        Mem_S = 1'b0;
        repeat (4) @(negedge clk);
        chk("mem_queue_empty", 32'(exp_m.size()), 32'd0);
        chk("if_queue_empty", 32'(exp_i.size()), 32'd0);
        chk("wr_queue_empty", 32'(exp_w.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
